// File: rtl/cpu_run_monitor.sv
// Run controller and monitor for one or more CPU cores.
// Gates the run, counts cycles/retires, captures the terminating cause.
module cpu_run_monitor #(
  parameter int NUM_CH    = 1,
  parameter int CNT_W     = 32,
  parameter int TIMEOUT   = 100000,
  parameter int DRAIN_CYC = 1,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_,
  input  logic                    start,
  input  logic [NUM_CH-1:0]       halt,
  input  logic [NUM_CH-1:0]       exception,
  input  logic [NUM_CH-1:0]       retire,
  output logic [CNT_W-1:0]        cycle_count,
  output logic [NUM_CH*CNT_W-1:0] retire_count,
  output logic                    running,
  output logic                    done,
  output logic [1:0]              cause,
  output logic [CH_W-1:0]         cause_ch,
  output logic                    illegal_pulse
);

  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;
  localparam logic [63:0] TO_M1 = 64'(TIMEOUT) - 64'd1;

  localparam logic [1:0] C_NONE = 2'b00;
  localparam logic [1:0] C_HALT = 2'b01;
  localparam logic [1:0] C_EXC  = 2'b10;
  localparam logic [1:0] C_TMO  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t            state;
  logic [DW-1:0]     drain_cnt;
  logic [CNT_W-1:0]  rc [NUM_CH];

  logic              ev_hit;
  logic              ev_halt;
  logic [CH_W-1:0]   ev_ch;
  logic              to_hit;

  // Descending scan so the lowest active channel is the last assignment.
  always_comb begin
    ev_hit  = 1'b0;
    ev_halt = 1'b0;
    ev_ch   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (halt[i] | exception[i]) begin
        ev_hit  = 1'b1;
        ev_halt = halt[i];
        ev_ch   = CH_W'(i);
      end
    end
  end

  assign to_hit = (TIMEOUT != 0) &&
                  (64'(cycle_count) == TO_M1);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_rc
    assign retire_count[g*CNT_W +: CNT_W] = rc[g];
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state         <= IDLE;
      cycle_count   <= '0;
      drain_cnt     <= '0;
      cause         <= C_NONE;
      cause_ch      <= '0;
      running       <= 1'b0;
      done          <= 1'b0;
      illegal_pulse <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) rc[i] <= '0;
    end else begin
      illegal_pulse <= 1'b0;

      // running mirrors RUN/DRAIN, where all counters advance.
      if (running) begin
        if (cycle_count != '1)
          cycle_count <= cycle_count + 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
          if (retire[i] && rc[i] != '1)
            rc[i] <= rc[i] + 1'b1;
        end
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (ev_hit | to_hit) begin
            if (ev_hit) begin
              cause         <= ev_halt ? C_HALT : C_EXC;
              cause_ch      <= ev_ch;
              illegal_pulse <= ~ev_halt;
            end else begin
              cause    <= C_TMO;
              cause_ch <= '0;
            end
            drain_cnt <= DW'(DRAIN_CYC);
            if (DRAIN_CYC == 0) begin
              state   <= DONE;
              running <= 1'b0;
              done    <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == DW'(1)) begin
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            state       <= RUN;
            running     <= 1'b1;
            done        <= 1'b0;
            cycle_count <= '0;
            cause       <= C_NONE;
            cause_ch    <= '0;
            for (int i = 0; i < NUM_CH; i++) rc[i] <= '0;
          end
        end
      endcase
    end
  end

endmodule
